mcs6530_bus_initiator: RTL and testbench
========================================

MCS6530_BUS_INITIATOR -- requirements
Module: mcs6530_bus_initiator

Interface
REQ-001 SHALL use one clock and one reset: clocking is single-clock, reset is synchronous and active-high.
REQ-002 FIFO_DEPTH, default 4, command queue depth (power of two, at least 2).
REQ-003 phi2  in  1  clock; every register updates on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  queue can accept a command.
REQ-007 cmd_we  in  1  1 = write, 0 = read.
REQ-008 cmd_rs_n  in  1  ROM-select level driven on the bus for this cycle.
REQ-009 cmd_addr  in  10  bus address.
REQ-010 cmd_wdata  in  8  write data.
REQ-011 rsp_valid  out  1  read data available.
REQ-012 rsp_ready  in  1  read data consumed.
REQ-013 rsp_rdata  out  8  captured read data.
REQ-014 bus_a  out  10  address to the responder.
REQ-015 bus_rs_n  out  1  ROM select, active-low.
REQ-016 bus_we_n  out  1  1 = read cycle, 0 = write cycle.
REQ-017 bus_db_o  out  8  write data.
REQ-018 bus_db_oe  out  1  data-bus drive enable.
REQ-019 bus_db_i  in  8  data returned by the responder.
REQ-020 busy  out  1  high when the queue is non-empty or the FSM is not IDLE.
REQ-021 rd_count, wr_count  out  16 each  number of completed reads and writes.

Function
REQ-022 Command queue SHALL be a FIFO of FIFO_DEPTH entries {we, rs_n, addr, wdata}.
  - Push on cmd_valid & cmd_ready.
  - cmd_ready = not full, registered-state based, with no combinational path from cmd_valid.
REQ-023 When full, cmd_ready SHALL be 0 and a simultaneous pop SHALL NOT allow a push in that same cycle.
REQ-024 FSM states SHALL be IDLE, ADDR, HOLD, CAPT, RESP.
REQ-025 IDLE with queue non-empty SHALL pop the head entry and go to ADDR on the next edge.
  - At that same edge, bus_a, bus_rs_n and bus_we_n = ~we load from the entry.
  - For a write, bus_db_o = wdata and bus_db_oe = 1 also load at that edge.
REQ-026 ADDR SHALL go to HOLD unconditionally, with all bus outputs held.
REQ-027 HOLD on a write SHALL go to IDLE.
  - At that edge bus_db_oe returns to 0, bus_we_n returns to 1, and wr_count increments.
  - Total write: 2 cycles from pop to bus release.
REQ-028 HOLD on a read SHALL go to CAPT.
REQ-029 CAPT SHALL register rsp_rdata <= bus_db_i, set rsp_valid = 1, increment rd_count, and go to RESP.
  - Read latency: rsp_valid rises 3 edges after the pop edge.
REQ-030 RESP SHALL hold rsp_valid and rsp_rdata stable until rsp_valid & rsp_ready, then clear rsp_valid and go to IDLE on that edge.
  - While in RESP, the FSM SHALL issue no new bus cycle, even if the queue is non-empty.
REQ-031 Back-to-back: IDLE is one cycle.
  - Consecutive writes therefore occupy 3 cycles each.
  - A read with rsp_ready held high occupies 5 cycles.
REQ-032 Bus idle values (IDLE, RESP):
  - bus_we_n = 1, bus_db_oe = 0, bus_rs_n = 1.
  - bus_a holds its last value.
  - bus_db_o holds its last value.
REQ-033 bus_db_oe SHALL never be 1 while bus_we_n = 1.
REQ-034 Counters SHALL be 16-bit, wrap 0xFFFF -> 0x0000, and never saturate.
REQ-035 A push to an empty queue while the FSM is in IDLE SHALL be popped on the following edge, not the same edge: queue write-to-pop latency is 1 cycle.

Reset
REQ-036 rst sampled high SHALL, at that edge, set:
  - FSM = IDLE and queue empty (pointers 0).
  - cmd_ready = 1, rsp_valid = 0, rsp_rdata = 0.
  - bus_a = 0, bus_rs_n = 1, bus_we_n = 1, bus_db_o = 0, bus_db_oe = 0.
  - busy = 0, rd_count = 0, wr_count = 0.
REQ-037 Reset mid-transaction SHALL abandon the cycle, release the data bus in the same edge, and discard all queued commands and any pending response.
REQ-038 rst SHALL take priority over push, pop and handshake in the same cycle.

Verification
REQ-039 Single write {we=1, addr=0x3F2, wdata=0xA5, rs_n=0}:
  - Edge after pop: bus_a=0x3F2, bus_we_n=0, bus_db_oe=1, bus_db_o=0xA5 for exactly 2 cycles.
  - Then bus_db_oe=0, bus_we_n=1, wr_count=1.
REQ-040 Single read {we=0, addr=0x080}, bus_db_i=0x5C, rsp_ready=1:
  - rsp_valid=1 with rsp_rdata=0x5C on the 3rd edge after pop, for one cycle.
  - rd_count=1, bus_db_oe=0 throughout.
REQ-041 Push 5 commands with no gaps while the FSM is stalled in RESP (rsp_ready=0):
  - cmd_ready falls after 4 queued.
  - The 5th push is held off until the stall clears.
  - Commands execute in order and none are lost.
REQ-042 Read with rsp_ready=0 for 10 cycles:
  - rsp_rdata stays stable and no bus cycle is issued.
  - On rsp_ready=1, rsp_valid drops on the next edge.
REQ-043 Assert rst during HOLD of a write:
  - Next edge: bus_db_oe=0, bus_we_n=1, queue empty, counters 0, cmd_ready=1.
REQ-044 Preset wr_count=0xFFFF via 65535 writes, then 1 more write -> wr_count=0x0000.

Source files
------------

// File: rtl/mcs6530_bus_initiator.sv
// Queued bus initiator for an MCS6530-style responder: commands are buffered in a
// small FIFO and replayed as fixed-timing read/write bus cycles clocked by phi2.
module mcs6530_bus_initiator #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        phi2,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic        cmd_rs_n,
    input  logic [9:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic [9:0]  bus_a,
    output logic        bus_rs_n,
    output logic        bus_we_n,
    output logic [7:0]  bus_db_o,
    output logic        bus_db_oe,
    input  logic [7:0]  bus_db_i,
    output logic        busy,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 20;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        HOLD,
        CAPT,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;

    logic [9:0]  bus_a_q, bus_a_d;
    logic        bus_rs_n_q, bus_rs_n_d;
    logic        bus_we_n_q, bus_we_n_d;
    logic [7:0]  bus_db_o_q, bus_db_o_d;
    logic        bus_db_oe_q, bus_db_oe_d;
    logic        cur_we_q, cur_we_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic               head_we;
    logic               head_rs_n;
    logic [9:0]         head_addr;
    logic [7:0]         head_wdata;

    // Ready depends only on the stored fill level, so a pop in a full cycle cannot admit a push.
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = (count_q != FULL_COUNT);
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state_q == IDLE) && !fifo_empty;

    assign head       = fifo_mem_q[rd_ptr_q];
    assign head_we    = head[19];
    assign head_rs_n  = head[18];
    assign head_addr  = head[17:8];
    assign head_wdata = head[7:0];

    always_ff @(posedge phi2) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= {cmd_we, cmd_rs_n, cmd_addr, cmd_wdata};
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge phi2) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_a_q     <= '0;
            bus_rs_n_q  <= 1'b1;
            bus_we_n_q  <= 1'b1;
            bus_db_o_q  <= '0;
            bus_db_oe_q <= 1'b0;
            cur_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            bus_a_q     <= bus_a_d;
            bus_rs_n_q  <= bus_rs_n_d;
            bus_we_n_q  <= bus_we_n_d;
            bus_db_o_q  <= bus_db_o_d;
            bus_db_oe_q <= bus_db_oe_d;
            cur_we_q    <= cur_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    // Bus pins are registered: each state decides what they show after the coming edge.
    always_comb begin
        state_d     = state_q;
        bus_a_d     = bus_a_q;
        bus_rs_n_d  = bus_rs_n_q;
        bus_we_n_d  = bus_we_n_q;
        bus_db_o_d  = bus_db_o_q;
        bus_db_oe_d = bus_db_oe_q;
        cur_we_d    = cur_we_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d    = ADDR;
                    cur_we_d   = head_we;
                    bus_a_d    = head_addr;
                    bus_rs_n_d = head_rs_n;
                    bus_we_n_d = ~head_we;
                    if (head_we) begin
                        bus_db_o_d  = head_wdata;
                        bus_db_oe_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (cur_we_q) begin
                    state_d     = IDLE;
                    bus_db_oe_d = 1'b0;
                    bus_we_n_d  = 1'b1;
                    bus_rs_n_d  = 1'b1;
                    wr_count_d  = wr_count_q + 16'd1;
                end else begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                state_d     = RESP;
                rsp_rdata_d = bus_db_i;
                rsp_valid_d = 1'b1;
                rd_count_d  = rd_count_q + 16'd1;
                bus_rs_n_d  = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_a     = bus_a_q;
    assign bus_rs_n  = bus_rs_n_q;
    assign bus_we_n  = bus_we_n_q;
    assign bus_db_o  = bus_db_o_q;
    assign bus_db_oe = bus_db_oe_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_mcs6530_bus_initiator.sv
// Bench for mcs6530_bus_initiator: directed timing steps plus randomized traffic checked
// against a transaction-level command queue and an address-derived responder.
module tb_mcs6530_bus_initiator;

    logic        phi2;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic        cmd_rs_n;
    logic [9:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic [9:0]  bus_a;
    logic        bus_rs_n;
    logic        bus_we_n;
    logic [7:0]  bus_db_o;
    logic        bus_db_oe;
    logic [7:0]  bus_db_i;
    logic        busy;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    typedef struct {
        logic       we;
        logic       rsn;
        logic [9:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    cmd_t        mq[$];
    int          compared;
    int          mismatched;
    int          oeRun;
    logic [15:0] expWr;
    logic [15:0] expRd;
    logic        randReady;
    logic [7:0]  dbNoise;

    mcs6530_bus_initiator #(.FIFO_DEPTH(4)) dut (
        .phi2      (phi2),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_rs_n  (cmd_rs_n),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .bus_a     (bus_a),
        .bus_rs_n  (bus_rs_n),
        .bus_we_n  (bus_we_n),
        .bus_db_o  (bus_db_o),
        .bus_db_oe (bus_db_oe),
        .bus_db_i  (bus_db_i),
        .busy      (busy),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    initial begin
        phi2 = 1'b0;
        forever #5 phi2 = ~phi2;
    end

    function automatic logic [7:0] respData(input logic [9:0] a);
        return a[7:0] ^ 8'hDC ^ {6'b0, a[9:8]};
    endfunction

    always_comb bus_db_i = respData(bus_a) ^ dbNoise;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with transaction monitoring against the reference queue.
    task automatic tick();
        logic       hs;
        logic       pv;
        logic       poe;
        logic       prst;
        logic [7:0] prd;
        logic [9:0] pa;
        cmd_t       c;
        if (randReady) rsp_ready = 1'($urandom_range(0, 1));
        hs   = rsp_valid & rsp_ready;
        pv   = rsp_valid;
        poe  = bus_db_oe;
        prst = rst;
        prd  = rsp_rdata;
        pa   = bus_a;
        @(posedge phi2);
        #1;
        if (prst) begin
            mq.delete();
            expWr = '0;
            expRd = '0;
            oeRun = 0;
        end else begin
            checkOutput("oeOnlyWhenWriting", {31'b0, bus_db_oe & bus_we_n}, 0);
            if (!poe && bus_db_oe) begin
                checkOutput("writeExpected", {31'b0, mq.size() != 0}, 1);
                if (mq.size() != 0) begin
                    c = mq.pop_front();
                    checkOutput("writeKind", {31'b0, c.we}, 1);
                    checkOutput("writeAddr", {22'b0, bus_a}, {22'b0, c.addr});
                    checkOutput("writeData", {24'b0, bus_db_o}, {24'b0, c.wdata});
                    checkOutput("writeRsN", {31'b0, bus_rs_n}, {31'b0, c.rsn});
                end
                oeRun = 1;
            end else if (poe && bus_db_oe) begin
                oeRun++;
            end
            if (poe && !bus_db_oe) checkOutput("writeDriveCycles", oeRun, 2);
            if (pv) begin
                checkOutput("rspValidHandshake", {31'b0, rsp_valid}, {31'b0, !hs});
                if (!hs) begin
                    checkOutput("rspDataStable", {24'b0, rsp_rdata}, {24'b0, prd});
                    checkOutput("stallNoBusWe", {31'b0, bus_we_n}, 1);
                    checkOutput("stallNoBusRs", {31'b0, bus_rs_n}, 1);
                    checkOutput("stallBusAddr", {22'b0, bus_a}, {22'b0, pa});
                end
            end else if (rsp_valid) begin
                checkOutput("readExpected", {31'b0, mq.size() != 0}, 1);
                if (mq.size() != 0) begin
                    c = mq.pop_front();
                    checkOutput("readKind", {31'b0, c.we}, 0);
                    checkOutput("readData", {24'b0, rsp_rdata}, {24'b0, respData(c.addr)});
                end
            end
        end
    endtask

    // Offer one command and wait (bounded) until the queue takes it.
    task automatic applyStimulus(input logic we, input logic rsn, input logic [9:0] a, input logic [7:0] d);
        int   n;
        cmd_t c;
        n         = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_rs_n  = rsn;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 300) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checkOutput("pushTimeout", {31'b0, cmd_ready}, 1);
        end else begin
            c.we = we; c.rsn = rsn; c.addr = a; c.wdata = d;
            mq.push_back(c);
            if (we) expWr = expWr + 16'd1;
            else    expRd = expRd + 16'd1;
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic waitRspValid();
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        checkOutput("rspValidTimeout", {31'b0, rsp_valid}, 1);
    endtask

    task automatic drain();
        int n;
        n         = 0;
        randReady = 1'b0;
        rsp_ready = 1'b1;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        checkOutput("drainBusy", {31'b0, busy}, 0);
        checkOutput("drainQueueModel", mq.size(), 0);
        checkOutput("drainWrCount", {16'b0, wr_count}, {16'b0, expWr});
        checkOutput("drainRdCount", {16'b0, rd_count}, {16'b0, expRd});
        checkOutput("drainCmdReady", {31'b0, cmd_ready}, 1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        oeRun      = 0;
        expWr      = '0;
        expRd      = '0;
        randReady  = 1'b0;
        dbNoise    = '0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_rs_n   = 1'b1;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        rsp_ready  = 1'b0;

        $display("[TB] reset");
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rstCmdReady", {31'b0, cmd_ready}, 1);
        checkOutput("rstRspValid", {31'b0, rsp_valid}, 0);
        checkOutput("rstRspData", {24'b0, rsp_rdata}, 0);
        checkOutput("rstBusA", {22'b0, bus_a}, 0);
        checkOutput("rstBusRsN", {31'b0, bus_rs_n}, 1);
        checkOutput("rstBusWeN", {31'b0, bus_we_n}, 1);
        checkOutput("rstBusDbO", {24'b0, bus_db_o}, 0);
        checkOutput("rstBusDbOe", {31'b0, bus_db_oe}, 0);
        checkOutput("rstBusy", {31'b0, busy}, 0);
        checkOutput("rstRdCount", {16'b0, rd_count}, 0);
        checkOutput("rstWrCount", {16'b0, wr_count}, 0);

        $display("[TB] single write");
        rsp_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 10'h3F2, 8'hA5);
        checkOutput("wrNotYetPopped", {31'b0, bus_we_n}, 1);
        checkOutput("wrBusyQueued", {31'b0, busy}, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("wrBusA", {22'b0, bus_a}, 32'h3F2);
            checkOutput("wrBusWeN", {31'b0, bus_we_n}, 0);
            checkOutput("wrBusOe", {31'b0, bus_db_oe}, 1);
            checkOutput("wrBusDbO", {24'b0, bus_db_o}, 32'hA5);
            checkOutput("wrBusRsN", {31'b0, bus_rs_n}, 0);
        end
        tick();
        checkOutput("wrReleaseOe", {31'b0, bus_db_oe}, 0);
        checkOutput("wrReleaseWeN", {31'b0, bus_we_n}, 1);
        checkOutput("wrReleaseRsN", {31'b0, bus_rs_n}, 1);
        checkOutput("wrCountOne", {16'b0, wr_count}, 1);
        checkOutput("wrHoldDbO", {24'b0, bus_db_o}, 32'hA5);

        $display("[TB] single read");
        applyStimulus(1'b0, 1'b0, 10'h080, 8'h00);
        tick();
        checkOutput("rdBusA", {22'b0, bus_a}, 32'h080);
        checkOutput("rdBusWeN", {31'b0, bus_we_n}, 1);
        checkOutput("rdBusRsN", {31'b0, bus_rs_n}, 0);
        checkOutput("rdResponderValue", {24'b0, bus_db_i}, 32'h5C);
        for (int i = 0; i < 2; i++) begin
            checkOutput("rdNotYetValid", {31'b0, rsp_valid}, 0);
            checkOutput("rdOeLow", {31'b0, bus_db_oe}, 0);
            tick();
        end
        checkOutput("rdNotYetValid3", {31'b0, rsp_valid}, 0);
        tick();
        checkOutput("rdValidThirdEdge", {31'b0, rsp_valid}, 1);
        checkOutput("rdData", {24'b0, rsp_rdata}, 32'h5C);
        checkOutput("rdCountOne", {16'b0, rd_count}, 1);
        checkOutput("rdOeLowResp", {31'b0, bus_db_oe}, 0);
        tick();
        checkOutput("rdValidOneCycle", {31'b0, rsp_valid}, 0);
        drain();

        $display("[TB] read held 10 cycles");
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 1'b1, 10'($urandom_range(0, 1023)), 8'h00);
        waitRspValid();
        dbNoise = 8'hFF;
        applyStimulus(1'b1, 1'b0, 10'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 9; i++) tick();
        checkOutput("stallStillValid", {31'b0, rsp_valid}, 1);
        checkOutput("stallBusyQueued", {31'b0, busy}, 1);
        dbNoise   = 8'h00;
        rsp_ready = 1'b1;
        tick();
        checkOutput("stallReleaseDrop", {31'b0, rsp_valid}, 0);
        drain();

        $display("[TB] queue fills during stall");
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 10'h155, 8'h00);
        waitRspValid();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          10'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)));
        end
        checkOutput("fullCmdReadyLow", {31'b0, cmd_ready}, 0);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_rs_n  = 1'b0;
        cmd_addr  = 10'h2AA;
        cmd_wdata = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("fullHeldOff", {31'b0, cmd_ready}, 0);
        end
        rsp_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 10'h2AA, 8'h3C);
        drain();

        $display("[TB] reset during write hold");
        applyStimulus(1'b1, 1'b1, 10'h011, 8'h77);
        applyStimulus(1'b1, 1'b0, 10'h022, 8'h88);
        checkOutput("preRstOe", {31'b0, bus_db_oe}, 1);
        tick();
        cmd_valid = 1'b1;
        rst       = 1'b1;
        tick();
        cmd_valid = 1'b0;
        rst       = 1'b0;
        checkOutput("midRstOe", {31'b0, bus_db_oe}, 0);
        checkOutput("midRstWeN", {31'b0, bus_we_n}, 1);
        checkOutput("midRstBusy", {31'b0, busy}, 0);
        checkOutput("midRstWrCount", {16'b0, wr_count}, 0);
        checkOutput("midRstRdCount", {16'b0, rd_count}, 0);
        checkOutput("midRstCmdReady", {31'b0, cmd_ready}, 1);
        tick();
        tick();
        checkOutput("midRstQueueDiscarded", {31'b0, bus_db_oe | busy}, 0);

        $display("[TB] randomized traffic");
        randReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          10'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();

        $display("[TB] write counter wrap");
        force dut.wr_count_q = 16'hFFFF;
        tick();
        release dut.wr_count_q;
        expWr = 16'hFFFF;
        tick();
        applyStimulus(1'b1, 1'b0, 10'h3FF, 8'h01);
        drain();
        checkOutput("wrCountWrap", {16'b0, wr_count}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
